// File: rtl/clk_divider_prog.sv
// ---------------------------------------------------------------------------
// clk_divider_prog
//   Multi-channel, run-time programmable even-ratio clock divider. Channel c
//   produces a 50%-duty clock of period 2*A[c] clockin cycles plus a one-cycle
//   tick on every rising edge of that clock, usable as a clock enable.
//   A new divisor is held in a shadow register and only becomes active at a
//   half-period boundary, so the output never glitches.
//
// Ports
//   clockin   in   1     system clock, rising-edge
//   reset_n   in   1     asynchronous active-low reset
//   en        in   1     global count enable (0 freezes every channel)
//   sync      in   1     synchronous restart of every channel (phase align)
//   wr_en     in   1     divisor write strobe
//   wr_ch     in   CW    channel select for the write
//   wr_div    in   W     divisor (half-period in clockin cycles)
//   clockout  out  N_CH  divided clocks
//   tick      out  N_CH  one-cycle pulse on each 0->1 of clockout
//   busy      out  N_CH  a written divisor is pending
// ---------------------------------------------------------------------------
module clk_divider_prog #(
    parameter  int N_CH    = 4,
    parameter  int W       = 16,
    parameter  int DEF_DIV = 8192,
    localparam int CW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clockin,
    input  logic            reset_n,
    input  logic            en,
    input  logic            sync,
    input  logic            wr_en,
    input  logic [CW-1:0]   wr_ch,
    input  logic [W-1:0]    wr_div,
    output logic [N_CH-1:0] clockout,
    output logic [N_CH-1:0] tick,
    output logic [N_CH-1:0] busy
);

    logic [W-1:0]    cnt_q [N_CH];
    logic [W-1:0]    cnt_d [N_CH];
    logic [W-1:0]    a_q   [N_CH];
    logic [W-1:0]    a_d   [N_CH];
    logic [W-1:0]    s_q   [N_CH];
    logic [W-1:0]    s_d   [N_CH];
    logic [N_CH-1:0] p_q, p_d;
    logic [N_CH-1:0] clk_q, clk_d;
    logic [N_CH-1:0] tick_q, tick_d;
    logic [N_CH-1:0] wr_hit;

    // A select value outside 0..N_CH-1 matches no channel, so such writes
    // are dropped without an explicit range comparison.
    always_comb begin
        wr_hit = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            wr_hit[ch] = wr_en && (wr_ch == CW'(ch));
        end
    end

    always_comb begin
        p_d    = p_q;
        clk_d  = clk_q;
        tick_d = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            cnt_d[ch] = cnt_q[ch];
            a_d[ch]   = a_q[ch];
            s_d[ch]   = s_q[ch];

            if (sync) begin
                cnt_d[ch] = '0;
                clk_d[ch] = 1'b0;
                // A write coinciding with sync bypasses the shadow stage.
                if (wr_hit[ch]) begin
                    a_d[ch] = wr_div;
                    s_d[ch] = wr_div;
                    p_d[ch] = 1'b0;
                end else if (p_q[ch]) begin
                    a_d[ch] = s_q[ch];
                    p_d[ch] = 1'b0;
                end
            end else begin
                if (en) begin
                    if (a_q[ch] == '0) begin
                        // Halted channel: no terminal count exists, so a
                        // pending divisor is taken on the very next edge.
                        cnt_d[ch] = '0;
                        clk_d[ch] = 1'b0;
                        if (p_q[ch]) begin
                            a_d[ch] = s_q[ch];
                            p_d[ch] = 1'b0;
                        end
                    end else if (cnt_q[ch] == W'(a_q[ch] - W'(1))) begin
                        cnt_d[ch]  = '0;
                        clk_d[ch]  = ~clk_q[ch];
                        tick_d[ch] = ~clk_q[ch];
                        if (p_q[ch]) begin
                            a_d[ch] = s_q[ch];
                            p_d[ch] = 1'b0;
                        end
                    end else begin
                        cnt_d[ch] = W'(cnt_q[ch] + W'(1));
                    end
                end
                // Applied after the terminal-edge transfer so that a write on
                // that same edge queues behind the divisor just activated.
                if (wr_hit[ch]) begin
                    s_d[ch] = wr_div;
                    p_d[ch] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clockin or negedge reset_n) begin
        if (!reset_n) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                cnt_q[ch] <= '0;
                a_q[ch]   <= W'(DEF_DIV);
                s_q[ch]   <= W'(DEF_DIV);
            end
            p_q    <= '0;
            clk_q  <= '0;
            tick_q <= '0;
        end else begin
            for (int ch = 0; ch < N_CH; ch++) begin
                cnt_q[ch] <= cnt_d[ch];
                a_q[ch]   <= a_d[ch];
                s_q[ch]   <= s_d[ch];
            end
            p_q    <= p_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign clockout = clk_q;
    assign tick     = tick_q;
    assign busy     = p_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// ---------------------------------------------------------------------------
// tb_clk_divider_prog
//   Directed bench for clk_divider_prog. The main instance uses the default
//   parameters; a second 3-channel instance exercises writes to a channel
//   number that does not exist (wr_ch = 3).
// ---------------------------------------------------------------------------
module tb_clk_divider_prog;

    logic        clockin = 1'b0;
    logic        reset_n;
    logic        en, sync, wr_en;
    logic [1:0]  wr_ch;
    logic [15:0] wr_div;
    logic [3:0]  clockout, tick, busy;

    logic        en3, sync3, wr_en3;
    logic [1:0]  wr_ch3;
    logic [7:0]  wr_div3;
    logic [2:0]  clockout3, tick3, busy3;

    int nvec = 0;
    int nerr = 0;

    clk_divider_prog #(.N_CH(4), .W(16), .DEF_DIV(8192)) u_dut (
        .clockin(clockin), .reset_n(reset_n), .en(en), .sync(sync),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
        .clockout(clockout), .tick(tick), .busy(busy)
    );

    clk_divider_prog #(.N_CH(3), .W(8), .DEF_DIV(2)) u_dut3 (
        .clockin(clockin), .reset_n(reset_n), .en(en3), .sync(sync3),
        .wr_en(wr_en3), .wr_ch(wr_ch3), .wr_div(wr_div3),
        .clockout(clockout3), .tick(tick3), .busy(busy3)
    );

    always #5 clockin = ~clockin;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clockin);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; en = 1'b0; sync = 1'b0; wr_en = 1'b0; wr_ch = 2'd0; wr_div = 16'd0;
        en3 = 1'b0; sync3 = 1'b0; wr_en3 = 1'b0; wr_ch3 = 2'd0; wr_div3 = 8'd0;
        repeat (3) step();
        nvec++; if (clockout !== 4'h0) begin nerr++; $display("FAIL reset_clockout got %h exp 0", clockout); end
        nvec++; if (tick !== 4'h0) begin nerr++; $display("FAIL reset_tick got %h exp 0", tick); end
        nvec++; if (busy !== 4'h0) begin nerr++; $display("FAIL reset_busy got %h exp 0", busy); end
        nvec++; if (clockout3 !== 3'h0) begin nerr++; $display("FAIL reset_clockout3 got %h exp 0", clockout3); end
        reset_n = 1'b1;
        en = 1'b1;
    endtask

    task automatic test_default();
        for (int k = 1; k <= 16384; k++) begin
            step();
            if (k == 8191) begin
                nvec++; if (clockout !== 4'h0) begin nerr++; $display("FAIL default_pre_rise got %h exp 0", clockout); end
            end
            if (k == 8192) begin
                nvec++; if (clockout !== 4'hF) begin nerr++; $display("FAIL default_rise got %h exp f", clockout); end
                nvec++; if (tick !== 4'hF) begin nerr++; $display("FAIL default_tick got %h exp f", tick); end
                nvec++; if (busy !== 4'h0) begin nerr++; $display("FAIL default_busy got %h exp 0", busy); end
            end
            if (k == 8193) begin
                nvec++; if (tick !== 4'h0) begin nerr++; $display("FAIL default_tick_len got %h exp 0", tick); end
            end
            if (k == 16383) begin
                nvec++; if (clockout !== 4'hF) begin nerr++; $display("FAIL default_pre_fall got %h exp f", clockout); end
            end
            if (k == 16384) begin
                nvec++; if (clockout !== 4'h0) begin nerr++; $display("FAIL default_fall got %h exp 0", clockout); end
                nvec++; if (tick !== 4'h0) begin nerr++; $display("FAIL default_fall_tick got %h exp 0", tick); end
            end
        end
    endtask

    task automatic test_fast();
        logic exp;
        wr_en = 1'b1; wr_ch = 2'd1; wr_div = 16'd1;
        step();
        wr_en = 1'b0;
        nvec++; if (busy !== 4'b0010) begin nerr++; $display("FAIL fast_busy_set got %b exp 0010", busy); end
        sync = 1'b1;
        step();
        sync = 1'b0;
        nvec++; if (busy !== 4'h0) begin nerr++; $display("FAIL fast_busy_clear got %b exp 0000", busy); end
        nvec++; if (clockout !== 4'h0) begin nerr++; $display("FAIL fast_sync_clk got %h exp 0", clockout); end
        for (int e = 1; e <= 6; e++) begin
            step();
            exp = (e % 2 == 1);
            nvec++; if (clockout[1] !== exp) begin nerr++; $display("FAIL fast_clk e=%0d got %b exp %b", e, clockout[1], exp); end
            nvec++; if (tick[1] !== exp) begin nerr++; $display("FAIL fast_tick e=%0d got %b exp %b", e, tick[1], exp); end
        end
    endtask

    task automatic test_change();
        logic ec, et, eb;
        sync = 1'b1; wr_en = 1'b1; wr_ch = 2'd2; wr_div = 16'd5;
        step();
        sync = 1'b0; wr_en = 1'b0;
        nvec++; if (busy[2] !== 1'b0) begin nerr++; $display("FAIL change_sync_write_busy got %b exp 0", busy[2]); end
        for (int e = 1; e <= 19; e++) begin
            wr_en = (e == 7); wr_ch = 2'd2; wr_div = 16'd3;
            step();
            ec = (e >= 5 && e <= 9) || (e >= 13 && e <= 15) || (e == 19);
            et = (e == 5) || (e == 13) || (e == 19);
            eb = (e >= 7 && e <= 9);
            nvec++; if (clockout[2] !== ec) begin nerr++; $display("FAIL change_clk e=%0d got %b exp %b", e, clockout[2], ec); end
            nvec++; if (tick[2] !== et) begin nerr++; $display("FAIL change_tick e=%0d got %b exp %b", e, tick[2], et); end
            nvec++; if (busy[2] !== eb) begin nerr++; $display("FAIL change_busy e=%0d got %b exp %b", e, busy[2], eb); end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_halt();
        logic ec, et, eb;
        sync = 1'b1; wr_en = 1'b1; wr_ch = 2'd3; wr_div = 16'd2;
        step();
        sync = 1'b0; wr_en = 1'b0;
        for (int e = 1; e <= 22; e++) begin
            wr_en = (e == 3) || (e == 9); wr_ch = 2'd3; wr_div = (e == 3) ? 16'd0 : 16'd4;
            step();
            ec = (e >= 2 && e <= 3) || (e >= 14 && e <= 17) || (e == 22);
            et = (e == 2) || (e == 14) || (e == 22);
            eb = (e == 3) || (e == 9);
            nvec++; if (clockout[3] !== ec) begin nerr++; $display("FAIL halt_clk e=%0d got %b exp %b", e, clockout[3], ec); end
            nvec++; if (tick[3] !== et) begin nerr++; $display("FAIL halt_tick e=%0d got %b exp %b", e, tick[3], et); end
            nvec++; if (busy[3] !== eb) begin nerr++; $display("FAIL halt_busy e=%0d got %b exp %b", e, busy[3], eb); end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_align_freeze();
        int   eff;
        logic ec, et;
        sync = 1'b1; wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd6;
        step();
        sync = 1'b0; wr_en = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            wr_en = (e == 2); wr_ch = 2'd1; wr_div = 16'd6;
            step();
        end
        wr_en = 1'b0;
        nvec++; if (clockout[1:0] !== 2'b01) begin nerr++; $display("FAIL align_offset got %b exp 01", clockout[1:0]); end
        nvec++; if (busy !== 4'h0) begin nerr++; $display("FAIL align_busy got %b exp 0000", busy); end
        sync = 1'b1;
        step();
        sync = 1'b0;
        nvec++; if (clockout[1:0] !== 2'b00) begin nerr++; $display("FAIL align_sync got %b exp 00", clockout[1:0]); end
        for (int rel = 1; rel <= 30; rel++) begin
            en = !(rel >= 9 && rel <= 18);
            step();
            eff = (rel <= 8) ? rel : ((rel <= 18) ? 8 : rel - 10);
            ec = ((eff / 6) % 2) == 1;
            et = en && (eff % 12 == 6);
            nvec++; if (clockout[1:0] !== {ec, ec}) begin nerr++; $display("FAIL align_clk rel=%0d got %b exp %b%b", rel, clockout[1:0], ec, ec); end
            nvec++; if (tick[1:0] !== {et, et}) begin nerr++; $display("FAIL align_tick rel=%0d got %b exp %b%b", rel, tick[1:0], et, et); end
        end
        en = 1'b1;
    endtask

    task automatic test_bad_channel();
        logic ec, et;
        en3 = 1'b1; sync3 = 1'b1;
        step();
        sync3 = 1'b0;
        nvec++; if (clockout3 !== 3'b000) begin nerr++; $display("FAIL badch_sync got %b exp 000", clockout3); end
        for (int e = 1; e <= 12; e++) begin
            wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_div3 = 8'd5;
            step();
            ec = ((e / 2) % 2) == 1;
            et = (e % 4 == 2);
            nvec++; if (clockout3 !== {3{ec}}) begin nerr++; $display("FAIL badch_clk e=%0d got %b exp %b", e, clockout3, {3{ec}}); end
            nvec++; if (tick3 !== {3{et}}) begin nerr++; $display("FAIL badch_tick e=%0d got %b exp %b", e, tick3, {3{et}}); end
            nvec++; if (busy3 !== 3'b000) begin nerr++; $display("FAIL badch_busy e=%0d got %b exp 000", e, busy3); end
        end
        wr_en3 = 1'b0;
    endtask

    task automatic test_reset_mid();
        wr_en = 1'b1; wr_ch = 2'd2; wr_div = 16'd9;
        step();
        wr_en = 1'b0;
        nvec++; if (busy[2] !== 1'b1) begin nerr++; $display("FAIL rstmid_pending got %b exp 1", busy[2]); end
        nvec++; if (clockout[0] !== 1'b1) begin nerr++; $display("FAIL rstmid_running got %b exp 1", clockout[0]); end
        #2;
        reset_n = 1'b0;
        #1;
        nvec++; if (clockout !== 4'h0) begin nerr++; $display("FAIL rstmid_clockout got %h exp 0", clockout); end
        nvec++; if (tick !== 4'h0) begin nerr++; $display("FAIL rstmid_tick got %h exp 0", tick); end
        nvec++; if (busy !== 4'h0) begin nerr++; $display("FAIL rstmid_busy got %h exp 0", busy); end
        nvec++; if (clockout3 !== 3'h0) begin nerr++; $display("FAIL rstmid_clockout3 got %h exp 0", clockout3); end
        #1;
        reset_n = 1'b1;
        en = 1'b1; sync = 1'b0;
        for (int k = 1; k <= 8192; k++) begin
            step();
            if (k == 8191) begin
                nvec++; if (clockout !== 4'h0) begin nerr++; $display("FAIL rstmid_pre_rise got %h exp 0", clockout); end
            end
            if (k == 8192) begin
                nvec++; if (clockout !== 4'hF) begin nerr++; $display("FAIL rstmid_rise got %h exp f", clockout); end
                nvec++; if (tick !== 4'hF) begin nerr++; $display("FAIL rstmid_tick_rise got %h exp f", tick); end
                nvec++; if (busy !== 4'h0) begin nerr++; $display("FAIL rstmid_busy_after got %h exp 0", busy); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_fast();
        test_change();
        test_halt();
        test_align_freeze();
        test_bad_channel();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
